// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and its consumers
interface vga_timing_gen_if;
    logic       blink_hold;
    logic       pix_tick;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_start;
    logic       blink_en;

    modport master (
        input  blink_hold,
        output pix_tick, hCount, vCount, hSync, vSync, bright, frame_start, blink_en
    );

    modport slave (
        output blink_hold,
        input  pix_tick, hCount, vCount, hSync, vSync, bright, frame_start, blink_en
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel divider, 800x525 raster counters, sync/bright decode and blink enable
// Optional macro VGA_SYNC_ALIGN_EN registers hSync/vSync/bright for one extra clk of latency.
module vga_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_VIS_START  = 144,
    parameter int H_VIS_END    = 784,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_VIS_START  = 35,
    parameter int V_VIS_END    = 515,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             frame_start_q, frame_start_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_en_q, blink_en_d;

    logic div_wrap, h_wrap, v_wrap;
    logic hs_dec, vs_dec, br_dec;

    always_comb begin
        div_wrap      = (div_q == DIV_W'(CLK_DIV - 1));
        h_wrap        = (h_q == 10'(H_TOTAL - 1));
        v_wrap        = (v_q == 10'(V_TOTAL - 1));
        div_d         = div_wrap ? '0 : div_q + 1'b1;
        pix_tick_d    = div_wrap;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = div_wrap && h_wrap && v_wrap;
        if (div_wrap) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // The blink counter reacts to the clk in which the frame_start strobe is visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_en_d  = blink_en_q;
        if (vga.blink_hold) begin
            blink_cnt_d = '0;
            blink_en_d  = 1'b1;
        end else if (frame_start_q) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_en_d  = ~blink_en_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
            blink_cnt_q   <= '0;
            blink_en_q    <= 1'b1;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_en_q    <= blink_en_d;
        end
    end

    always_comb begin
        hs_dec = (h_q >= 10'(H_SYNC));
        vs_dec = (v_q >= 10'(V_SYNC));
        br_dec = (h_q >= 10'(H_VIS_START)) && (h_q < 10'(H_VIS_END)) &&
                 (v_q >= 10'(V_VIS_START)) && (v_q < 10'(V_VIS_END));
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_q, vs_q, br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            br_q <= 1'b0;
        end else begin
            hs_q <= hs_dec;
            vs_q <= vs_dec;
            br_q <= br_dec;
        end
    end

    assign vga.hSync  = hs_q;
    assign vga.vSync  = vs_q;
    assign vga.bright = br_q;
`else
    assign vga.hSync  = hs_dec;
    assign vga.vSync  = vs_dec;
    assign vga.bright = br_dec;
`endif

    assign vga.pix_tick    = pix_tick_q;
    assign vga.hCount      = h_q;
    assign vga.vCount      = v_q;
    assign vga.frame_start = frame_start_q;
    assign vga.blink_en    = blink_en_q;
endmodule
